// File: rtl/t01_ai_mmu_pkg.sv
// t01_ai_mmu_pkg: shared widths, FSM state encoding and result narrowing
// for the t01 AI matrix-vector unit.
// Optional feature macro: T01_AI_MMU_SAT_EN (saturating narrowing; wrap otherwise).
package t01_ai_mmu_pkg;

  localparam int ACT_W_D   = 8;
  localparam int W_W_D     = 8;
  localparam int ACC_W_D   = 24;
  localparam int OUT_W_D   = 18;
  localparam int MAX_IN_D  = 32;
  localparam int MAX_OUT_D = 32;
  localparam int WADDR_W_D = 12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_BIAS = 3'd2,
    S_MAC  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // Narrow a sign-extended sum to ow bits; the caller keeps the low ow bits.
  function automatic logic signed [63:0] narrow(input logic signed [63:0] v, input int ow);
`ifdef T01_AI_MMU_SAT_EN
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (ow - 1));
    if (v > mx)      return mx;
    else if (v < mn) return mn;
    else             return v;
`else
    return (v <<< (64 - ow)) >>> (64 - ow);
`endif
  endfunction

endpackage

// File: rtl/t01_ai_mmu_if.sv
// t01_ai_mmu_if: control, activation, weight-memory and result signals
// of the matrix-vector unit. slave = the unit, master = its environment.
interface t01_ai_mmu_if
  import t01_ai_mmu_pkg::*;
#(
  parameter int ACT_W   = ACT_W_D,
  parameter int W_W     = W_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int WADDR_W = WADDR_W_D,
  parameter int NIN_W   = $clog2(MAX_IN_D + 1),
  parameter int NOUT_W  = $clog2(MAX_OUT_D + 1)
);
  logic               start;
  logic [NIN_W-1:0]   n_in;
  logic [NOUT_W-1:0]  n_out;
  logic [WADDR_W-1:0] w_base;
  logic               relu_en;
  logic               act_valid;
  logic               act_ready;
  logic [ACT_W-1:0]   act_in;
  logic [WADDR_W-1:0] w_addr;
  logic [W_W-1:0]     w_rdata;
  logic               res_valid;
  logic               res_ready;
  logic [OUT_W-1:0]   res_out;
  logic               res_last;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, n_in, n_out, w_base, relu_en, act_valid, act_in, w_rdata, res_ready,
    input  act_ready, w_addr, res_valid, res_out, res_last, busy, done, err
  );

  modport slave (
    input  start, n_in, n_out, w_base, relu_en, act_valid, act_in, w_rdata, res_ready,
    output act_ready, w_addr, res_valid, res_out, res_last, busy, done, err
  );
endinterface

// File: rtl/t01_ai_mac.sv
// t01_ai_mac: signed multiply-accumulate with bias preload, ReLU and
// narrowing to the result width. Accumulator wraps modulo 2^ACC_W.
// Narrowing follows T01_AI_MMU_SAT_EN through the package narrow().
module t01_ai_mac
  import t01_ai_mmu_pkg::*;
#(
  parameter int ACT_W = ACT_W_D,
  parameter int W_W   = W_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bias_ld,
  input  logic                    mac_en,
  input  logic                    relu_en,
  input  logic signed [ACT_W-1:0] act,
  input  logic signed [W_W-1:0]   wdata,
  output logic signed [OUT_W-1:0] res
);
  localparam int PW = ACT_W + W_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [63:0]      wide;

  assign prod = PW'(act) * PW'(wdata);

  // Bias seeds the accumulator; each returned weight adds one product.
  always_ff @(posedge clk) begin
    if (rst)          acc <= '0;
    else if (bias_ld) acc <= {{(ACC_W-W_W){wdata[W_W-1]}}, wdata};
    else if (mac_en)  acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
  end

  assign sum  = (relu_en && acc[ACC_W-1]) ? '0 : acc;
  assign wide = {{(64-ACC_W){sum[ACC_W-1]}}, sum};
  assign res  = OUT_W'(narrow(wide, OUT_W));
endmodule

// File: rtl/t01_ai_mmu_param.sv
// t01_ai_mmu_param: layer matrix-vector unit. Buffers n_in activations,
// then per neuron streams bias + n_in weights from a 1-cycle-latency
// weight memory, accumulates, applies ReLU/narrowing and hands out results.
// Optional feature macro: T01_AI_MMU_SAT_EN (saturating result narrowing).
module t01_ai_mmu_param
  import t01_ai_mmu_pkg::*;
#(
  parameter int ACT_W   = ACT_W_D,
  parameter int W_W     = W_W_D,
  parameter int ACC_W   = ACC_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int MAX_IN  = MAX_IN_D,
  parameter int MAX_OUT = MAX_OUT_D,
  parameter int WADDR_W = WADDR_W_D
) (
  input logic          clk,
  input logic          rst,
  t01_ai_mmu_if.slave  bus
);
  localparam int NIN_W  = $clog2(MAX_IN + 1);
  localparam int NOUT_W = $clog2(MAX_OUT + 1);
  localparam int IDX_W  = $clog2(MAX_IN);

  localparam logic [2:0] IDLE = S_IDLE;
  localparam logic [2:0] LOAD = S_LOAD;
  localparam logic [2:0] BIAS = S_BIAS;
  localparam logic [2:0] MAC  = S_MAC;
  localparam logic [2:0] OUT  = S_OUT;
  localparam logic [2:0] DONE = S_DONE;

  logic [2:0]              state;
  logic [NIN_W-1:0]        n_in_q, cnt;
  logic [NOUT_W-1:0]       n_out_q, nrn;
  logic [WADDR_W-1:0]      base_q, addr_cnt;
  logic                    relu_q, err_q;
  logic signed [ACT_W-1:0] act_buf [MAX_IN];
  logic signed [ACT_W-1:0] mac_act;
  logic signed [OUT_W-1:0] mac_res;
  logic                    cfg_ok, last_in, last_nrn;

  assign cfg_ok   = (bus.n_in  != '0) && (bus.n_in  <= NIN_W'(MAX_IN)) &&
                    (bus.n_out != '0) && (bus.n_out <= NOUT_W'(MAX_OUT));
  assign last_in  = (cnt == n_in_q - 1'b1);
  assign last_nrn = (nrn == n_out_q - 1'b1);

  // Control FSM: cnt indexes activations in LOAD and the MAC step in MAC;
  // addr_cnt runs across all rows so w_addr needs no multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      nrn      <= '0;
      addr_cnt <= '0;
      n_in_q   <= '0;
      n_out_q  <= '0;
      base_q   <= '0;
      relu_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= bus.start && ((state != IDLE) || !cfg_ok);
      case (state)
        IDLE: if (bus.start && cfg_ok) begin
          state    <= LOAD;
          n_in_q   <= bus.n_in;
          n_out_q  <= bus.n_out;
          base_q   <= bus.w_base;
          relu_q   <= bus.relu_en;
          cnt      <= '0;
          nrn      <= '0;
          addr_cnt <= '0;
        end
        LOAD: if (bus.act_valid) begin
          if (last_in) begin
            state <= BIAS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BIAS: begin
          addr_cnt <= addr_cnt + 1'b1;
          state    <= MAC;
        end
        MAC: begin
          // cnt == n_in is the drain step: no address issued
          if (cnt == n_in_q) begin
            state <= OUT;
          end else begin
            cnt      <= cnt + 1'b1;
            addr_cnt <= addr_cnt + 1'b1;
          end
        end
        OUT: if (bus.res_ready) begin
          if (last_nrn) begin
            state <= DONE;
          end else begin
            state <= BIAS;
            nrn   <= nrn + 1'b1;
            cnt   <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Activation buffer; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.act_valid) act_buf[cnt[IDX_W-1:0]] <= bus.act_in;
  end

  // Data returned at MAC step cnt belongs to the address issued at cnt-1.
  assign mac_act = act_buf[IDX_W'(cnt - 1'b1)];

  t01_ai_mac #(
    .ACT_W (ACT_W),
    .W_W   (W_W),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .bias_ld (state == MAC && cnt == '0),
    .mac_en  (state == MAC && cnt != '0),
    .relu_en (relu_q),
    .act     (mac_act),
    .wdata   (bus.w_rdata),
    .res     (mac_res)
  );

  assign bus.act_ready = (state == LOAD);
  assign bus.w_addr    = base_q + addr_cnt;
  assign bus.res_valid = (state == OUT);
  assign bus.res_out   = bus.res_valid ? mac_res : '0;
  assign bus.res_last  = bus.res_valid && last_nrn;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.err       = err_q;
endmodule
